store_commit_buffer: RTL

- Consumer end of the commit-stage store protocol: the store data buffer (SDB) that receives store commit and store flush notifications from the ROB.
- Holds stores in program order, from AGU allocation until drain to the D-cache write port.
- Entries are SPECULATIVE until committed, then COMMITTED until written to memory.
- Branch-miss recovery removes the youngest speculative entries.

---
 rtl/store_commit_buffer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/store_commit_buffer.sv
`default_nettype none
// ============================================================================
// Module      : store_commit_buffer
// Description : Store data buffer. Holds stores in program order from
//               allocation until they drain to the D-cache write port.
//               Entries are speculative until the ROB commits them, and
//               branch-miss flushes remove the youngest speculative entries.
//               Optional store-to-load forwarding is enabled by STORE_FWD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module store_commit_buffer #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    alloc_valid,
    input  logic [ADDR_W-1:0]       alloc_addr,
    input  logic [DATA_W-1:0]       alloc_data,
    input  logic [DATA_W/8-1:0]     alloc_mask,
    output logic                    alloc_ready,
    input  logic                    store_commit_0_valid,
    input  logic                    store_commit_1_valid,
    input  logic                    store_flush_0_valid,
    input  logic                    store_flush_1_valid,
    output logic                    mem_req_valid,
    output logic [ADDR_W-1:0]       mem_req_addr,
    output logic [DATA_W-1:0]       mem_req_data,
    output logic [DATA_W/8-1:0]     mem_req_mask,
    input  logic                    mem_req_ready,
    output logic [$clog2(DEPTH):0]  entry_count,
    output logic                    empty
`ifdef STORE_FWD_EN
    ,
    input  logic [ADDR_W-1:0]       fwd_addr,
    output logic                    fwd_hit,
    output logic [DATA_W-1:0]       fwd_data,
    output logic [DATA_W/8-1:0]     fwd_mask
`endif
);

    localparam int c_idx_w  = $clog2(DEPTH);
    localparam int c_ptr_w  = c_idx_w + 1;
    localparam int c_mask_w = DATA_W / 8;

    logic [ADDR_W-1:0]   r_addr [DEPTH];
    logic [DATA_W-1:0]   r_data [DEPTH];
    logic [c_mask_w-1:0] r_mask [DEPTH];

    logic [c_ptr_w-1:0]  r_head;
    logic [c_ptr_w-1:0]  r_cptr;
    logic [c_ptr_w-1:0]  r_tail;

    logic [c_ptr_w-1:0]  w_committed;
    logic [c_ptr_w-1:0]  w_spec;
    logic [c_ptr_w-1:0]  w_count;
    logic [c_ptr_w-1:0]  w_ncommit;
    logic [c_ptr_w-1:0]  w_nflush;
    logic [c_ptr_w-1:0]  w_commit_apply;
    logic [c_ptr_w-1:0]  w_spec_left;
    logic [c_ptr_w-1:0]  w_flush_apply;
    logic                w_flush_any;
    logic                w_alloc_fire;
    logic                w_drain_fire;

    assign w_committed = r_cptr - r_head;
    assign w_spec      = r_tail - r_cptr;
    assign w_count     = r_tail - r_head;

    // A lone commit_1 still counts as a single commit, which the sum gives.
    assign w_ncommit = c_ptr_w'(store_commit_0_valid) + c_ptr_w'(store_commit_1_valid);
    assign w_nflush  = c_ptr_w'(store_flush_0_valid) + c_ptr_w'(store_flush_1_valid);

    // Commits are applied before flushes, so flushes only see what is left.
    assign w_commit_apply = (w_ncommit > w_spec) ? w_spec : w_ncommit;
    assign w_spec_left    = w_spec - w_commit_apply;
    assign w_flush_apply  = (w_nflush > w_spec_left) ? w_spec_left : w_nflush;

    assign w_flush_any  = store_flush_0_valid | store_flush_1_valid;
    assign alloc_ready  = (w_count < c_ptr_w'(DEPTH)) && !w_flush_any;
    assign w_alloc_fire = alloc_valid && alloc_ready;

    assign mem_req_valid = (w_committed != '0);
    assign mem_req_addr  = r_addr[r_head[c_idx_w-1:0]];
    assign mem_req_data  = r_data[r_head[c_idx_w-1:0]];
    assign mem_req_mask  = r_mask[r_head[c_idx_w-1:0]];
    assign w_drain_fire  = mem_req_valid && mem_req_ready;

    assign entry_count = w_count;
    assign empty       = (r_tail == r_head);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head <= '0;
            r_cptr <= '0;
            r_tail <= '0;
        end else begin
            r_head <= r_head + c_ptr_w'(w_drain_fire);
            r_cptr <= r_cptr + w_commit_apply;
            r_tail <= r_tail - w_flush_apply + c_ptr_w'(w_alloc_fire);
        end
    end

    // Payload storage needs no reset: only slots between head and tail are read.
    always_ff @(posedge clk) begin
        if (rst_n && w_alloc_fire) begin
            r_addr[r_tail[c_idx_w-1:0]] <= alloc_addr;
            r_data[r_tail[c_idx_w-1:0]] <= alloc_data;
            r_mask[r_tail[c_idx_w-1:0]] <= alloc_mask;
        end
    end

    a_commit_in_range : assert property (@(posedge clk) disable iff (!rst_n)
        w_ncommit <= w_spec);

`ifdef STORE_FWD_EN
    logic [c_idx_w-1:0] w_slot;

    // Scan oldest to youngest so the youngest matching entry overrides.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_mask = '0;
        w_slot   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_slot = r_head[c_idx_w-1:0] + c_idx_w'(k);
            if ((c_ptr_w'(k) < w_count) &&
                (r_addr[w_slot][ADDR_W-1:2] == fwd_addr[ADDR_W-1:2])) begin
                fwd_hit  = 1'b1;
                fwd_data = r_data[w_slot];
                fwd_mask = r_mask[w_slot];
            end
        end
    end
`endif

endmodule
`default_nettype wire
